// File: rtl/phivers_link_pkg.sv
// -----------------------------------------------------------------------------
// phivers_link_pkg
// Shared constants and helpers for the Phivers NoC link buffer.
//   LINK_FLIT_WIDTH  - default data bits per flit (eop carried separately)
//   LINK_DEPTH       - default number of buffer entries (power of two, >= 2)
//   LINK_CNT_WIDTH   - default width of the flit/packet counters
//   LINK_STALL_LIMIT - default blocked-cycle threshold for the watchdog
//   link_log2()      - log2 of a power-of-two depth, used for pointer sizing
// -----------------------------------------------------------------------------
package phivers_link_pkg;

    localparam int LINK_FLIT_WIDTH  = 32;
    localparam int LINK_DEPTH       = 2;
    localparam int LINK_CNT_WIDTH   = 16;
    localparam int LINK_STALL_LIMIT = 256;

    // Width of the watchdog stall counter.
    localparam int LINK_STALL_CNT_WIDTH = 16;

    // Returns the smallest r with 2**r >= depth (exact log2 for powers of two).
    function automatic int link_log2(input int depth);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < depth) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage : phivers_link_pkg

// File: rtl/phivers_link_fifo.sv
// -----------------------------------------------------------------------------
// phivers_link_fifo
// DEPTH-entry retiming buffer for one link. Credit (wr_ready) and valid
// (rd_valid) are derived only from the registered occupancy count and the
// reset input, so no combinational path crosses the buffer.
// Ports:
//   clk_i     in   clock
//   rst_i     in   synchronous active-high reset
//   wr_valid  in   upstream entry valid
//   wr_ready  out  buffer can accept an entry (credit)
//   wr_data   in   entry to store
//   rd_valid  out  head entry valid
//   rd_ready  in   downstream accepts head entry
//   rd_data   out  head entry
//   pop       out  head entry is consumed at this edge
// -----------------------------------------------------------------------------
module phivers_link_fifo
    import phivers_link_pkg::*;
#(
    parameter int WIDTH = LINK_FLIT_WIDTH + 1,
    parameter int DEPTH = LINK_DEPTH
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             wr_valid,
    output logic             wr_ready,
    input  logic [WIDTH-1:0] wr_data,
    output logic             rd_valid,
    input  logic             rd_ready,
    output logic [WIDTH-1:0] rd_data,
    output logic             pop
);

    localparam int PTR_W = link_log2(DEPTH);
    localparam logic [PTR_W:0] FULL_COUNT = (PTR_W + 1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr_reg;
    logic [PTR_W-1:0] rd_ptr_reg;
    logic [PTR_W:0]   count_reg;
    logic             push;

    // Reset forces both handshakes low so nothing moves while rst_i is held.
    assign wr_ready = !rst_i && (count_reg != FULL_COUNT);
    assign rd_valid = !rst_i && (count_reg != '0);

    assign push = wr_valid && wr_ready;
    assign pop  = rd_valid && rd_ready;

    assign rd_data = mem[rd_ptr_reg];

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            if (push && !pop) begin
                count_reg <= count_reg + 1'b1;
            end else if (pop && !push) begin
                count_reg <= count_reg - 1'b1;
            end
        end
    end

    // Storage carries no reset; stale entries are never visible because
    // rd_valid is gated by the count.
    always_ff @(posedge clk_i) begin
        if (push) begin
            mem[wr_ptr_reg] <= wr_data;
        end
    end

endmodule : phivers_link_fifo

// File: rtl/phivers_link_buf.sv
// -----------------------------------------------------------------------------
// phivers_link_buf
// Credit-based router-to-router link stage: a DEPTH-entry retiming buffer
// plus delivered-flit / delivered-packet counters and a sticky stall
// watchdog that flags a downstream port withholding credit for
// STALL_LIMIT consecutive cycles while a flit is waiting.
// Ports:
//   clk_i       in   clock
//   rst_i       in   synchronous active-high reset
//   tx_i        in   upstream flit valid
//   cr_tx_o     out  credit to upstream
//   eop_tx_i    in   upstream flit is last of packet
//   data_tx_i   in   upstream flit data
//   rx_o        out  flit valid toward downstream
//   cr_rx_i     in   credit from downstream
//   eop_rx_o    out  head flit is last of packet
//   data_rx_o   out  head flit data
//   clr_i       in   clears counters and the stall flag
//   flit_cnt_o  out  flits delivered downstream (wrapping)
//   pkt_cnt_o   out  packets delivered downstream (wrapping)
//   stall_o     out  sticky watchdog flag
// -----------------------------------------------------------------------------
module phivers_link_buf
    import phivers_link_pkg::*;
#(
    parameter int FLIT_WIDTH  = LINK_FLIT_WIDTH,
    parameter int DEPTH       = LINK_DEPTH,
    parameter int CNT_WIDTH   = LINK_CNT_WIDTH,
    parameter int STALL_LIMIT = LINK_STALL_LIMIT
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  tx_i,
    output logic                  cr_tx_o,
    input  logic                  eop_tx_i,
    input  logic [FLIT_WIDTH-1:0] data_tx_i,
    output logic                  rx_o,
    input  logic                  cr_rx_i,
    output logic                  eop_rx_o,
    output logic [FLIT_WIDTH-1:0] data_rx_o,
    input  logic                  clr_i,
    output logic [CNT_WIDTH-1:0]  flit_cnt_o,
    output logic [CNT_WIDTH-1:0]  pkt_cnt_o,
    output logic                  stall_o
);

    localparam int ENTRY_W = FLIT_WIDTH + 1;
    localparam logic [LINK_STALL_CNT_WIDTH-1:0] STALL_LAST =
        LINK_STALL_CNT_WIDTH'(STALL_LIMIT - 1);

    logic [ENTRY_W-1:0]              head;
    logic                            pop;
    logic [CNT_WIDTH-1:0]            flit_cnt_reg;
    logic [CNT_WIDTH-1:0]            pkt_cnt_reg;
    logic [LINK_STALL_CNT_WIDTH-1:0] stall_cnt_reg;
    logic                            stall_reg;

    phivers_link_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .wr_valid (tx_i),
        .wr_ready (cr_tx_o),
        .wr_data  ({eop_tx_i, data_tx_i}),
        .rd_valid (rx_o),
        .rd_ready (cr_rx_i),
        .rd_data  (head),
        .pop      (pop)
    );

    assign eop_rx_o  = head[FLIT_WIDTH];
    assign data_rx_o = head[FLIT_WIDTH-1:0];

    assign flit_cnt_o = flit_cnt_reg;
    assign pkt_cnt_o  = pkt_cnt_reg;
    assign stall_o    = stall_reg;

    // Delivery counters; a clear wins over a same-cycle pop.
    always_ff @(posedge clk_i) begin
        if (rst_i || clr_i) begin
            flit_cnt_reg <= '0;
            pkt_cnt_reg  <= '0;
        end else if (pop) begin
            flit_cnt_reg <= flit_cnt_reg + 1'b1;
            if (eop_rx_o) begin
                pkt_cnt_reg <= pkt_cnt_reg + 1'b1;
            end
        end
    end

    // Watchdog: stall_cnt_reg holds the number of consecutive blocked cycles
    // already completed, so the flag sets on the edge that ends blocked cycle
    // number STALL_LIMIT. Any pop or an empty buffer restarts the run; once
    // the flag is set the counter simply holds.
    always_ff @(posedge clk_i) begin
        if (rst_i || clr_i) begin
            stall_cnt_reg <= '0;
            stall_reg     <= 1'b0;
        end else if (pop || !rx_o) begin
            stall_cnt_reg <= '0;
        end else if (!stall_reg) begin
            if (stall_cnt_reg == STALL_LAST) begin
                stall_reg <= 1'b1;
            end else begin
                stall_cnt_reg <= stall_cnt_reg + 1'b1;
            end
        end
    end

endmodule : phivers_link_buf

// File: tb/tb_phivers_link_buf.sv
// -----------------------------------------------------------------------------
// tb_phivers_link_buf
// Self-checking bench for phivers_link_buf (DEPTH=2, CNT_WIDTH=4,
// STALL_LIMIT=8). A scoreboard queue holds flits accepted upstream; every
// cycle the bench's own occupancy/counter/watchdog model is compared with
// the DUT, and each delivered flit is popped from the queue and compared.
// -----------------------------------------------------------------------------
module tb_phivers_link_buf;

    localparam int FW    = 32;
    localparam int DEPTH = 2;
    localparam int CW    = 4;
    localparam int SL    = 8;

    typedef logic [FW:0] entry_t;

    typedef struct {
        logic          tx;
        logic          eop;
        logic [FW-1:0] data;
        logic          cr_rx;
        logic          x_cr;
        logic          x_rx;
        logic [CW-1:0] x_flit;
        logic [CW-1:0] x_pkt;
    } vec_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          tx;
    logic          cr_tx;
    logic          eop_tx;
    logic [FW-1:0] data_tx;
    logic          rx;
    logic          cr_rx;
    logic          eop_rx;
    logic [FW-1:0] data_rx;
    logic          clr;
    logic [CW-1:0] flit_cnt;
    logic [CW-1:0] pkt_cnt;
    logic          stall;

    entry_t        sb_q[$];
    logic [CW-1:0] m_flit;
    logic [CW-1:0] m_pkt;
    logic          m_stall;
    int            m_run;

    int n_cmp = 0;
    int n_bad = 0;
    int n_pop = 0;

    vec_t tbl[11];

    always #5 clk = ~clk;

    phivers_link_buf #(
        .FLIT_WIDTH  (FW),
        .DEPTH       (DEPTH),
        .CNT_WIDTH   (CW),
        .STALL_LIMIT (SL)
    ) dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .tx_i       (tx),
        .cr_tx_o    (cr_tx),
        .eop_tx_i   (eop_tx),
        .data_tx_i  (data_tx),
        .rx_o       (rx),
        .cr_rx_i    (cr_rx),
        .eop_rx_o   (eop_rx),
        .data_rx_o  (data_rx),
        .clr_i      (clr),
        .flit_cnt_o (flit_cnt),
        .pkt_cnt_o  (pkt_cnt),
        .stall_o    (stall)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Called one time unit after a rising edge; leaves outputs settled.
    task automatic drive(input logic r, input logic t, input logic e,
                         input logic [FW-1:0] d, input logic c, input logic cl);
        rst     = r;
        tx      = t;
        eop_tx  = e;
        data_tx = d;
        cr_rx   = c;
        clr     = cl;
        #1;
    endtask

    // Compare DUT with the model for the current cycle, then advance one edge
    // and update the model with what that edge must have done.
    task automatic check_and_step();
        logic   exp_cr;
        logic   exp_rx;
        logic   do_pop;
        logic   do_push;
        logic   blocked;
        entry_t head;
        head    = '0;
        exp_cr  = !rst && (sb_q.size() != DEPTH);
        exp_rx  = !rst && (sb_q.size() != 0);
        chk("cr_tx_o", cr_tx, exp_cr);
        chk("rx_o", rx, exp_rx);
        chk("flit_cnt_o", flit_cnt, m_flit);
        chk("pkt_cnt_o", pkt_cnt, m_pkt);
        chk("stall_o", stall, m_stall);
        do_pop  = exp_rx && cr_rx;
        do_push = exp_cr && tx;
        blocked = exp_rx && !cr_rx;
        if (do_pop) begin
            head = sb_q[0];
            chk("data_rx_o", data_rx, head[FW-1:0]);
            chk("eop_rx_o", eop_rx, head[FW]);
            n_pop++;
            $display("pop %0d: eop=%0b data=%08h", n_pop, eop_rx, data_rx);
        end
        @(posedge clk);
        #1;
        if (rst) begin
            sb_q.delete();
            m_flit  = '0;
            m_pkt   = '0;
            m_stall = 1'b0;
            m_run   = 0;
        end else begin
            if (do_pop) begin
                head = sb_q.pop_front();
            end
            if (do_push) begin
                sb_q.push_back({eop_tx, data_tx});
            end
            m_run = blocked ? m_run + 1 : 0;
            if (clr) begin
                m_flit  = '0;
                m_pkt   = '0;
                m_stall = 1'b0;
                m_run   = 0;
            end else begin
                if (do_pop) begin
                    m_flit = m_flit + 1'b1;
                    if (head[FW]) begin
                        m_pkt = m_pkt + 1'b1;
                    end
                end
                if (m_run >= SL) begin
                    m_stall = 1'b1;
                end
            end
        end
    endtask

    task automatic cyc(input logic r, input logic t, input logic e,
                       input logic [FW-1:0] d, input logic c, input logic cl);
        drive(r, t, e, d, c, cl);
        check_and_step();
    endtask

    function automatic vec_t mk(input logic t, input logic e, input logic [FW-1:0] d,
                                input logic c, input logic xc, input logic xr,
                                input logic [CW-1:0] xf, input logic [CW-1:0] xp);
        vec_t v;
        v.tx = t; v.eop = e; v.data = d; v.cr_rx = c;
        v.x_cr = xc; v.x_rx = xr; v.x_flit = xf; v.x_pkt = xp;
        return v;
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: simulation did not finish, expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        int sent;
        int budget;

        // Single flit, then back-pressure with a full buffer (DEPTH=2).
        //             tx  eop data           cr_rx  cr  rx  flit pkt
        tbl[0]  = mk(0, 0, 32'h0,          0,   1,  0,  0,   0);
        tbl[1]  = mk(1, 1, 32'hCAFE0001,   1,   1,  0,  0,   0);
        tbl[2]  = mk(0, 0, 32'h0,          1,   1,  1,  0,   0);
        tbl[3]  = mk(0, 0, 32'h0,          0,   1,  0,  1,   1);
        tbl[4]  = mk(1, 0, 32'hA0000001,   0,   1,  0,  1,   1);
        tbl[5]  = mk(1, 0, 32'hA0000002,   0,   1,  1,  1,   1);
        tbl[6]  = mk(1, 1, 32'hA0000003,   0,   0,  1,  1,   1);
        tbl[7]  = mk(0, 0, 32'h0,          1,   0,  1,  1,   1);
        tbl[8]  = mk(0, 0, 32'h0,          1,   1,  1,  2,   1);
        tbl[9]  = mk(0, 0, 32'h0,          1,   1,  0,  3,   1);
        tbl[10] = mk(0, 0, 32'h0,          0,   1,  0,  3,   1);

        // Initial reset; registers are unknown until the first reset edge.
        rst = 1'b1; tx = 1'b0; eop_tx = 1'b0; data_tx = '0; cr_rx = 1'b0; clr = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        m_flit = '0; m_pkt = '0; m_stall = 1'b0; m_run = 0;
        sb_q.delete();

        // Reset state: handshakes low while rst is held, counters zero.
        cyc(1, 1, 0, 32'h0, 1, 0);

        // ---------------- table-driven vectors ----------------
        for (int i = 0; i < 11; i++) begin
            drive(0, tbl[i].tx, tbl[i].eop, tbl[i].data, tbl[i].cr_rx, 0);
            chk($sformatf("tbl%0d_cr_tx", i), cr_tx, tbl[i].x_cr);
            chk($sformatf("tbl%0d_rx", i), rx, tbl[i].x_rx);
            chk($sformatf("tbl%0d_flit", i), flit_cnt, tbl[i].x_flit);
            chk($sformatf("tbl%0d_pkt", i), pkt_cnt, tbl[i].x_pkt);
            check_and_step();
        end

        // ---------------- watchdog fires on blocked cycle 8 ----------------
        cyc(0, 0, 0, 32'h0, 0, 1);
        cyc(0, 1, 1, 32'h57A11000, 0, 0);
        for (int k = 1; k <= SL + 3; k++) begin
            cyc(0, 0, 0, 32'h0, 0, 0);
            chk($sformatf("wd_blocked%0d_stall", k), stall, (k >= SL));
        end
        cyc(0, 0, 0, 32'h0, 1, 0);
        chk("wd_sticky_after_pop", stall, 1);
        cyc(0, 0, 0, 32'h0, 0, 0);
        chk("wd_sticky_idle", stall, 1);
        cyc(0, 0, 0, 32'h0, 0, 1);
        chk("wd_cleared", stall, 0);

        // ---------------- pop at blocked cycle 7 prevents the flag --------
        cyc(0, 1, 1, 32'h57A11001, 0, 0);
        for (int k = 1; k <= SL - 2; k++) begin
            cyc(0, 0, 0, 32'h0, 0, 0);
        end
        cyc(0, 1, 1, 32'h57A11002, 1, 0);
        chk("wd_prevent_stall", stall, 0);
        for (int k = 1; k <= SL - 1; k++) begin
            cyc(0, 0, 0, 32'h0, 0, 0);
            chk($sformatf("wd_rerun%0d_stall", k), stall, 0);
        end
        cyc(0, 0, 0, 32'h0, 1, 0);
        chk("wd_rerun_after_pop", stall, 0);

        // ---------------- counter wrap (CNT_WIDTH=4) and clear ------------
        cyc(0, 0, 0, 32'h0, 0, 1);
        for (int i = 0; i < 17; i++) begin
            cyc(0, 1, 1, $urandom, 1, 0);
        end
        cyc(0, 0, 0, 32'h0, 1, 0);
        chk("wrap_flit_cnt", flit_cnt, 17 % 16);
        chk("wrap_pkt_cnt", pkt_cnt, 17 % 16);
        cyc(0, 1, 1, 32'hC1EA0001, 0, 0);
        cyc(0, 0, 0, 32'h0, 1, 1);
        chk("clr_pop_flit_cnt", flit_cnt, 0);
        chk("clr_pop_pkt_cnt", pkt_cnt, 0);
        chk("clr_pop_rx", rx, 0);

        // ---------------- random streaming, 4-flit packets ----------------
        sent   = 0;
        budget = 0;
        while (sent < 1000 && budget < 20000) begin
            logic t;
            logic c;
            logic e;
            t = ($urandom_range(0, 3) != 0);
            c = ($urandom_range(0, 3) != 0);
            e = ((sent % 4) == 3);
            if (t && (sb_q.size() != DEPTH)) begin
                sent++;
            end
            cyc(0, t, e, $urandom, c, 0);
            budget++;
        end
        chk("stream_sent_within_budget", sent, 1000);
        budget = 0;
        while (sb_q.size() != 0 && budget < 20) begin
            cyc(0, 0, 0, 32'h0, 1, 0);
            budget++;
        end
        chk("stream_drained_rx", rx, 0);
        chk("stream_flit_cnt", flit_cnt, 1000 % 16);
        chk("stream_pkt_cnt", pkt_cnt, 250 % 16);
        cyc(0, 0, 0, 32'h0, 0, 1);

        // ---------------- reset with two flits buffered ----------------
        cyc(0, 1, 0, 32'hBEEF0001, 0, 0);
        cyc(0, 1, 1, 32'hBEEF0002, 0, 0);
        drive(1, 1, 0, 32'hBEEF0003, 1, 0);
        chk("rst_mid_cr_tx", cr_tx, 0);
        chk("rst_mid_rx", rx, 0);
        check_and_step();
        drive(0, 0, 0, 32'h0, 1, 0);
        chk("post_rst_cr_tx", cr_tx, 1);
        chk("post_rst_rx", rx, 0);
        chk("post_rst_flit_cnt", flit_cnt, 0);
        chk("post_rst_pkt_cnt", pkt_cnt, 0);
        chk("post_rst_stall", stall, 0);
        check_and_step();
        cyc(0, 0, 0, 32'h0, 1, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule : tb_phivers_link_buf
